// File: rtl/gray_count_receiver.sv
// Receives a Gray-coded count from a foreign clock domain, synchronizes and decodes it,
// and reports per-update deltas plus a sticky error on illegal multi-bit Gray steps.
module gray_count_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [DATA_WIDTH-1:0] gray_in,
   input  logic                  err_clr,
   output logic [DATA_WIDTH-1:0] bin_out,
   output logic                  upd,
   output logic [DATA_WIDTH-1:0] delta,
   output logic                  err,
   output logic                  ready
);

   typedef enum logic [1:0] {FILL, BASE, TRACK, FAULT} state_t;

   localparam int CW = $clog2(SYNC_STAGES + 1);
   localparam logic [CW-1:0] FILL_LAST = CW'(SYNC_STAGES - 1);

   state_t                                state, state_nx;
   logic [CW-1:0]                         fill_cnt, fill_nx;
   logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_q;
   logic [DATA_WIDTH-1:0]                 prev_gray;
   logic [DATA_WIDTH-1:0]                 sync_out, bin_dec, diff;
   logic                                  tracking, changed, multi;

   function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
      logic [DATA_WIDTH-1:0] b;
      b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
      for (int i = DATA_WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign bin_dec  = gray2bin(sync_out);
   assign diff     = sync_out ^ prev_gray;
   assign changed  = |diff;
   // Clearing the lowest set bit leaves something only when two or more bits moved.
   assign multi    = changed && |(diff & (diff - 1'b1));
   assign tracking = (state == TRACK) || (state == FAULT);
   assign ready    = tracking;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) begin
         state    <= FILL;
         fill_cnt <= '0;
      end else begin
         state    <= state_nx;
         fill_cnt <= fill_nx;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      state_nx = state;
      fill_nx  = fill_cnt;
      case (state)
         FILL:    if (fill_cnt == FILL_LAST) state_nx = BASE;
                  else                       fill_nx  = fill_cnt + 1'b1;
         BASE:    state_nx = TRACK;
         TRACK:   if (multi) state_nx = FAULT;
         FAULT:   if (!multi && err_clr) state_nx = TRACK;
         default: state_nx = FILL;
      endcase
   end

   // Plain flop chain: no logic between stages so each stage only resolves metastability.
   always_ff @(posedge clk) begin
      if (!resetn) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], gray_in};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev_gray <= '0;
         bin_out   <= '0;
         upd       <= 1'b0;
         delta     <= '0;
         err       <= 1'b0;
      end else begin
         upd   <= 1'b0;
         delta <= '0;
         if (state == BASE) begin
            prev_gray <= sync_out;
            bin_out   <= bin_dec;
         end else if (tracking && changed) begin
            prev_gray <= sync_out;
            bin_out   <= bin_dec;
            upd       <= 1'b1;
            delta     <= bin_dec - bin_out;
         end
         // A fresh illegal step outranks a concurrent clear request.
         if (tracking && multi)                err <= 1'b1;
         else if (state == FAULT && err_clr)   err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gray_count_receiver.sv
// Scoreboard bench for gray_count_receiver: expected updates are queued when gray_in is driven
// and compared whenever the DUT pulses upd.
module tb_gray_count_receiver;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] bin;
      logic [W-1:0] delta;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         resetn;
   logic [W-1:0] gray_in;
   logic         err_clr;
   logic [W-1:0] bin_out;
   logic         upd;
   logic [W-1:0] delta;
   logic         err;
   logic         ready;

   int   total = 0;
   int   bad   = 0;
   int   upd_count = 0;
   exp_t sb[$];

   gray_count_receiver #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .resetn(resetn), .gray_in(gray_in), .err_clr(err_clr),
      .bin_out(bin_out), .upd(upd), .delta(delta), .err(err), .ready(ready)
   );

   always #5 clk = ~clk;

   // Monitor: every upd pulse must match the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (upd) begin
            upd_count++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_upd: got bin=%0h delta=%0h err=%0b, expected no update",
                        bin_out, delta, err);
            end else begin
               e = sb.pop_front();
               if ({bin_out, delta, err} !== {e.bin, e.delta, e.err}) begin
                  bad++;
                  $display("FAIL upd_data: got bin=%0h delta=%0h err=%0b, expected bin=%0h delta=%0h err=%0b",
                           bin_out, delta, err, e.bin, e.delta, e.err);
               end
            end
         end else if (resetn && delta !== '0) begin
            total++;
            bad++;
            $display("FAIL delta_idle: got %0h, expected 0 while upd=0", delta);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic step(input logic [W-1:0] g, input logic [W-1:0] b, input logic [W-1:0] d,
                       input logic e);
      gray_in = g;
      sb.push_back('{bin: b, delta: d, err: e});
      wait_cycles(3);
   endtask

   task automatic check_drained(input string name);
      wait_cycles(2);
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL %s_drain: %0d updates still pending, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      gray_in = '0;
      err_clr = 1'b0;
      wait_cycles(2);
      total++;
      if ({bin_out, upd, delta, err, ready} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got bin=%0h upd=%0b delta=%0h err=%0b ready=%0b, expected all 0",
                  bin_out, upd, delta, err, ready);
      end
      resetn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_cycles(1);
         total++;
         if (ready !== (k == 3)) begin
            bad++;
            $display("FAIL ready_edge%0d: got %0b, expected %0b", k, ready, k == 3);
         end
      end
      wait_cycles(4);
      total++;
      if (bin_out !== 8'h00 || err !== 1'b0) begin
         bad++;
         $display("FAIL base_zero: got bin=%0h err=%0b, expected bin=0 err=0", bin_out, err);
      end
      check_drained("reset");
   endtask

   task automatic test_sequence();
      logic [W-1:0] b;
      upd_count = 0;
      for (int k = 1; k <= 256; k++) begin
         b = W'(k);
         step(bin2gray(b), b, 8'h01, 1'b0);
      end
      check_drained("sequence");
      total++;
      if (upd_count !== 256) begin
         bad++;
         $display("FAIL seq_count: got %0d upd pulses, expected 256", upd_count);
      end
      total++;
      if (bin_out !== 8'h00 || err !== 1'b0) begin
         bad++;
         $display("FAIL seq_final: got bin=%0h err=%0b, expected bin=0 err=0", bin_out, err);
      end
   endtask

   task automatic test_minus_one();
      step(8'h01, 8'h01, 8'h01, 1'b0);
      step(8'h00, 8'h00, 8'hFF, 1'b0);
      check_drained("minus_one");
   endtask

   task automatic test_illegal_clear();
      step(8'h03, 8'h02, 8'h02, 1'b1);
      wait_cycles(5);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: got %0b, expected 1", err);
      end
      err_clr = 1'b1;
      wait_cycles(1);
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0 || ready !== 1'b1) begin
         bad++;
         $display("FAIL err_clear: got err=%0b ready=%0b, expected err=0 ready=1", err, ready);
      end
      // Back in TRACK: a legal step must not raise err; err_clr there is ignored.
      step(8'h02, 8'h03, 8'h01, 1'b0);
      err_clr = 1'b1;
      wait_cycles(1);
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL track_legal: got err=%0b, expected 0", err);
      end
      step(8'h03, 8'h02, 8'hFF, 1'b0);
      check_drained("illegal");
   endtask

   task automatic test_fault_wins();
      step(8'h00, 8'h00, 8'hFE, 1'b1);
      step(8'h03, 8'h02, 8'h02, 1'b1);
      gray_in = 8'h0C;
      sb.push_back('{bin: 8'h08, delta: 8'h06, err: 1'b1});
      wait_cycles(2);
      err_clr = 1'b1;
      wait_cycles(1);
      err_clr = 1'b0;
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL fault_wins: got err=%0b, expected 1", err);
      end
      wait_cycles(3);
      total++;
      if (err !== 1'b1) begin
         bad++;
         $display("FAIL fault_hold: got err=%0b, expected 1", err);
      end
      check_drained("fault_wins");
   endtask

   task automatic test_reset_in_fault();
      resetn = 1'b0;
      wait_cycles(1);
      total++;
      if ({bin_out, upd, delta, err, ready} !== '0) begin
         bad++;
         $display("FAIL fault_reset: got bin=%0h upd=%0b delta=%0h err=%0b ready=%0b, expected all 0",
                  bin_out, upd, delta, err, ready);
      end
      resetn = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_cycles(1);
         total++;
         if (ready !== (k == 3)) begin
            bad++;
            $display("FAIL rearm_edge%0d: got ready=%0b, expected %0b", k, ready, k == 3);
         end
      end
      total++;
      if (bin_out !== 8'h08 || err !== 1'b0) begin
         bad++;
         $display("FAIL rearm_base: got bin=%0h err=%0b, expected bin=8 err=0", bin_out, err);
      end
      check_drained("reset_fault");
   endtask

   initial begin
      resetn  = 1'b0;
      gray_in = '0;
      err_clr = 1'b0;
      @(negedge clk);
      test_reset();
      test_sequence();
      test_minus_one();
      test_illegal_clear();
      test_fault_wins();
      test_reset_in_fault();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_count_receiver.md
GRAY_COUNT_RECEIVER -- requirements
Module: gray_count_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of the Gray-coded count (legal range 2..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer flop depth (legal range 2..4).
REQ-003 SHALL have input clk, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have input resetn, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have input gray_in, DATA_WIDTH bits: Gray-coded count driven by a counter in an unrelated clock domain.
REQ-006 SHALL have input err_clr, 1 bit: single-cycle request to clear the sticky error.
REQ-007 SHALL have output bin_out, DATA_WIDTH bits: synchronized count, decoded to binary and registered.
REQ-008 SHALL have output upd, 1 bit: one-cycle pulse; bin_out changed on this cycle.
REQ-009 SHALL have output delta, DATA_WIDTH bits: (new bin_out - previous bin_out) mod 2^DATA_WIDTH, valid while upd=1, else 0.
REQ-010 SHALL have output err, 1 bit: sticky flag; an illegal multi-bit Gray transition was seen.
REQ-011 SHALL have output ready, 1 bit: 1 once the baseline value is established (states TRACK and FAULT).

Function
REQ-012 SHALL pass gray_in through a chain of SYNC_STAGES flops with no logic between stages.
REQ-013 SHALL decode the last sync stage to binary: bit MSB = g[MSB]; bit i = b[i+1] XOR g[i], for i from MSB-1 down to 0.
REQ-014 SHALL hold a registered copy of the previous synchronized Gray value (prev_gray) for transition checks.
REQ-015 SHALL implement FSM states FILL, BASE, TRACK and FAULT.
REQ-016 SHALL, in FILL, count SYNC_STAGES cycles after reset release, with ready=0 and upd=0, then go to BASE.
REQ-017 SHALL, in BASE (one cycle), load bin_out and prev_gray from the sync output, keep upd=0, set ready=1 from the next cycle, and go to TRACK.
REQ-018 SHALL, in TRACK and FAULT, compare the sync output with prev_gray every cycle; if equal: no update, upd=0, delta=0.
REQ-019 SHALL, on a change of exactly one bit: load bin_out with the decoded value, update prev_gray, pulse upd, and drive delta per REQ-009 (+1 gives 1; -1 gives 2^DATA_WIDTH-1).
REQ-020 SHALL, on a change of two or more bits: still load bin_out and prev_gray, pulse upd with delta, set err=1, and go (or stay) in FAULT.
REQ-021 SHALL, in FAULT with err_clr=1 and no new illegal transition in that cycle: clear err the next cycle and return to TRACK.
REQ-022 SHALL, when err_clr and an illegal transition occur in the same cycle: keep err=1 and stay in FAULT (fault wins).
REQ-023 SHALL ignore err_clr in FILL, BASE and TRACK.
REQ-024 SHALL give a latency of SYNC_STAGES+1 edges: a gray_in change captured at edge E appears on bin_out, with upd=1, after edge E+SYNC_STAGES.
REQ-025 SHALL treat wrap-around (binary max to 0, a one-bit Gray change) as legal, with delta=1.
REQ-026 SHALL drive upd, delta and err from registers, not from combinational paths.

Reset
REQ-027 SHALL, while resetn=0 at a rising edge, clear all sync flops and prev_gray to 0 and enter FILL.
REQ-028 SHALL, on reset, set bin_out=0, upd=0, delta=0, err=0 and ready=0.
REQ-029 SHALL allow reset at any time, including during FAULT, and discard all history; after release, restart the FILL sequence.

Verification
REQ-030 Reset then hold gray_in=8'h00 -> ready rises after edge 3 (SYNC_STAGES+1), bin_out=0, upd never asserts, err=0.
REQ-031 Step gray_in through a 256-step Gray sequence (one step every 3 cycles), including 8'h80->8'h00 -> 256 upd pulses, each with delta=1, correct bin_out, err=0; after the last step bin_out=0.
REQ-032 Change gray_in from 8'h01 (bin 1) to 8'h00 (bin 0) -> upd=1, delta=8'hFF, err=0.
REQ-033 Change gray_in from 8'h00 to 8'h03 -> after edge E+2: bin_out=2, upd=1, delta=2, err=1 and stays 1; then pulse err_clr -> err=0 next cycle, state TRACK.
REQ-034 Raise err_clr in the same cycle as a second illegal transition (8'h03 to 8'h0C) -> err stays 1.
REQ-035 Assert resetn=0 for one cycle while in FAULT -> all outputs return to reset values, err=0, and ready re-asserts 3 cycles after release.
